// File: rtl/input_debouncer_if.sv
// Input-port bundle: raw switch bank and enter button in, captured data,
// write strobe and debounced level out.
interface input_debouncer_if #(
  parameter int WIDTH_DATA_LENGTH = 8
);
  logic [WIDTH_DATA_LENGTH-1:0] Switches;
  logic                         Button;
  logic [WIDTH_DATA_LENGTH-1:0] Data;
  logic                         Write;
  logic                         Pressed;

  modport master (output Switches, Button, input  Data, Write, Pressed);
  modport slave  (input  Switches, Button, output Data, Write, Pressed);
endinterface

// File: rtl/input_debouncer.sv
// Synchronises the switch bank and enter button, debounces the button and
// issues a one-cycle capture strobe per qualified press, plus optional auto-repeat.
module input_debouncer #(
  parameter int WIDTH_DATA_LENGTH = 8,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int REPEAT_CYCLES     = 0
) (
  input  logic                Clk,
  input  logic                Rst,
  input_debouncer_if.slave    io
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit REP_EN = (REPEAT_CYCLES > 0);
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t                       state, state_n;
  logic [CNT_W-1:0]             cnt, cnt_n;
  logic [REP_W-1:0]             rep, rep_n;
  logic [1:0]                   btn_sync;
  logic [WIDTH_DATA_LENGTH-1:0] sw_m, sw_s;
  logic                         btn_s;
  logic                         cap, press_set, press_clr;

  assign btn_s = btn_sync[1];

  // Two-flop synchronisers; switches are only sampled, never debounced.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      btn_sync <= '0;
      sw_m     <= '0;
      sw_s     <= '0;
    end else begin
      btn_sync <= {btn_sync[0], io.Button};
      sw_m     <= io.Switches;
      sw_s     <= sw_m;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
      rep   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rep   <= rep_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rep_n     = rep;
    cap       = 1'b0;
    press_set = 1'b0;
    press_clr = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n   = HELD;
          cap       = 1'b1;
          press_set = 1'b1;
          rep_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (REP_EN) begin
          // Repeat period counts from HELD entry; rep freezes once release starts.
          if (rep == REP_LAST) begin
            cap   = 1'b1;
            rep_n = '0;
          end else begin
            rep_n = rep + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = HELD;
          rep_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          press_clr = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      io.Data    <= '0;
      io.Write   <= 1'b0;
      io.Pressed <= 1'b0;
    end else begin
      io.Write <= cap;
      if (cap)       io.Data    <= sw_s;
      if (press_set) io.Pressed <= 1'b1;
      else if (press_clr) io.Pressed <= 1'b0;
    end
  end
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench: table-driven clean press/release on a default instance, then
// hand sequences for bounce, auto-repeat (second instance) and reset mid-press.
module tb_input_debouncer;
  logic Clk, Rst;
  int   nvec, nerr;

  input_debouncer_if #(.WIDTH_DATA_LENGTH(8)) bus0 ();
  input_debouncer_if #(.WIDTH_DATA_LENGTH(8)) bus1 ();

  input_debouncer #(.WIDTH_DATA_LENGTH(8), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0))
    dut0 (.Clk(Clk), .Rst(Rst), .io(bus0.slave));
  input_debouncer #(.WIDTH_DATA_LENGTH(8), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8))
    dut1 (.Clk(Clk), .Rst(Rst), .io(bus1.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       btn;
    logic [7:0] sw;
    logic       w;
    logic       p;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic b, logic [7:0] s, logic w, logic p, logic [7:0] d);
    vec_t v;
    v.btn = b; v.sw = s; v.w = w; v.p = p; v.d = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives happen 1 time unit after an edge, checks right after the next one.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int wcnt, wedge, pmin, fall;
    int redge [$];
    logic [7:0] rdata [$];
    nvec = 0;
    nerr = 0;

    // Rows: button/switches driven before edge k+i, outputs expected after it.
    tbl[0]  = mk(1, 8'hA5, 0, 0, 8'h00);
    tbl[1]  = mk(1, 8'hA5, 0, 0, 8'h00);
    tbl[2]  = mk(1, 8'hA5, 0, 0, 8'h00);
    tbl[3]  = mk(1, 8'hA5, 0, 0, 8'h00);
    tbl[4]  = mk(1, 8'hA5, 0, 0, 8'h00);
    tbl[5]  = mk(1, 8'hA5, 0, 0, 8'h00);
    tbl[6]  = mk(1, 8'hA5, 1, 1, 8'hA5);
    tbl[7]  = mk(1, 8'hA5, 0, 1, 8'hA5);
    tbl[8]  = mk(1, 8'hA5, 0, 1, 8'hA5);
    tbl[9]  = mk(1, 8'hA5, 0, 1, 8'hA5);
    tbl[10] = mk(0, 8'h0F, 0, 1, 8'hA5);
    tbl[11] = mk(0, 8'h0F, 0, 1, 8'hA5);
    tbl[12] = mk(0, 8'h0F, 0, 1, 8'hA5);
    tbl[13] = mk(0, 8'h0F, 0, 1, 8'hA5);
    tbl[14] = mk(0, 8'h0F, 0, 1, 8'hA5);
    tbl[15] = mk(0, 8'h0F, 0, 1, 8'hA5);
    tbl[16] = mk(0, 8'h0F, 0, 0, 8'hA5);
    tbl[17] = mk(0, 8'h0F, 0, 0, 8'hA5);
    tbl[18] = mk(0, 8'h0F, 0, 0, 8'hA5);
    tbl[19] = mk(0, 8'h0F, 0, 0, 8'hA5);

    // Asynchronous reset before any clock edge.
    Rst = 1'b1;
    bus0.Button = 1'b1; bus0.Switches = 8'hFF;
    bus1.Button = 1'b0; bus1.Switches = 8'h00;
    #1 Rst = 1'b0;
    #1;
    chk("rst_data",    bus0.Data,    8'h00);
    chk("rst_write",   bus0.Write,   1'b0);
    chk("rst_pressed", bus0.Pressed, 1'b0);

    bus0.Button = 1'b0; bus0.Switches = 8'h00;
    tick(); tick();
    Rst = 1'b1;
    tick(); tick(); tick();

    // Clean press and release.
    for (int i = 0; i < 20; i++) begin
      bus0.Button   = tbl[i].btn;
      bus0.Switches = tbl[i].sw;
      tick();
      chk($sformatf("vec%0d_write", i),   bus0.Write,   tbl[i].w);
      chk($sformatf("vec%0d_pressed", i), bus0.Pressed, tbl[i].p);
      chk($sformatf("vec%0d_data", i),    bus0.Data,    tbl[i].d);
    end

    // Press bounce: high 3, low 1, steady high from t=4; single write at t=10.
    bus0.Switches = 8'h96;
    wcnt = 0; wedge = -1;
    for (int t = 0; t < 18; t++) begin
      bus0.Button = (t == 3) ? 1'b0 : 1'b1;
      tick();
      if (bus0.Write) begin wcnt++; wedge = t; end
    end
    chk("pbounce_wr_cnt",  wcnt,  1);
    chk("pbounce_wr_edge", wedge, 10);
    chk("pbounce_pressed", bus0.Pressed, 1'b1);
    chk("pbounce_data",    bus0.Data,    8'h96);

    // Release bounce: low 2 cycles then high again.
    wcnt = 0; pmin = 1;
    for (int t = 0; t < 12; t++) begin
      bus0.Button = (t < 2) ? 1'b0 : 1'b1;
      tick();
      if (bus0.Write) wcnt++;
      if (!bus0.Pressed) pmin = 0;
    end
    chk("rbounce_wr_cnt",  wcnt, 0);
    chk("rbounce_pressed", pmin, 1);

    // Final release: Pressed falls 6 edges after raw low.
    wcnt = 0; fall = -1;
    bus0.Button = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (bus0.Write) wcnt++;
      if (fall < 0 && !bus0.Pressed) fall = t;
    end
    chk("release_fall_edge", fall, 6);
    chk("release_wr_cnt",    wcnt, 0);

    // Auto-repeat on the REPEAT_CYCLES=8 instance.
    bus1.Switches = 8'hA5;
    bus1.Button   = 1'b1;
    wedge = -1;
    for (int t = 0; t < 20 && wedge < 0; t++) begin
      tick();
      if (bus1.Write) wedge = t;
    end
    chk("rep_first_edge", wedge, 6);
    chk("rep_first_data", bus1.Data, 8'hA5);
    for (int t = 1; t <= 30; t++) begin
      if (t == 10) bus1.Switches = 8'h3C;
      tick();
      if (bus1.Write) begin redge.push_back(t); rdata.push_back(bus1.Data); end
    end
    chk("rep_count", redge.size(), 3);
    if (redge.size() == 3) begin
      chk("rep1_edge", redge[0], 8);  chk("rep1_data", rdata[0], 8'hA5);
      chk("rep2_edge", redge[1], 16); chk("rep2_data", rdata[1], 8'h3C);
      chk("rep3_edge", redge[2], 24); chk("rep3_data", rdata[2], 8'h3C);
    end
    chk("rep_pressed", bus1.Pressed, 1'b1);

    // Reset during PRESS_WAIT with the button held.
    bus0.Switches = 8'h5A;
    bus0.Button   = 1'b1;
    tick(); tick(); tick(); tick();
    Rst = 1'b0;
    #1;
    chk("midrst_data",     bus0.Data,    8'h00);
    chk("midrst_write",    bus0.Write,   1'b0);
    chk("midrst_pressed",  bus0.Pressed, 1'b0);
    chk("midrst_pressed1", bus1.Pressed, 1'b0);
    chk("midrst_data1",    bus1.Data,    8'h00);
    tick(); tick();
    Rst = 1'b1;
    wcnt = 0; wedge = -1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (bus0.Write) begin wcnt++; if (wedge < 0) wedge = t; end
    end
    chk("postrst_wr_edge", wedge, 6);
    chk("postrst_wr_cnt",  wcnt,  1);
    chk("postrst_data",    bus0.Data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
